// File: rtl/tpu_ctrl_pkg.sv
// Shared definitions for the TPU run-control blocks: FSM state encoding and
// default timing parameters of the array datapath.
package tpu_ctrl_pkg;

  localparam int ADDRESSSIZE_DEF = 10;
  localparam int LOAD_CYCLES_DEF = 8;
  localparam int PIPE_LAT_DEF    = 18;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WFIFO  = 3'd1,
    S_POP    = 3'd2,
    S_LOAD   = 3'd3,
    S_STREAM = 3'd4,
    S_DRAIN  = 3'd5,
    S_DONE   = 3'd6
  } state_t;

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-depth 1-bit shift register that delays the UB row-valid strobe to line
// up with the skewed array output at the result SRAM.
module valid_delay_line #(
  parameter int DEPTH = 18
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic next_out,
  output logic any_set
);

  logic [DEPTH-1:0] stages;

  // next_out is the bit that becomes dout on the coming edge, so the consumer
  // can register addresses in step with the delayed strobe.
  if (DEPTH == 1) begin : g_single
    always_ff @(posedge clk or posedge rst) begin
      if (rst) stages <= '0;
      else     stages <= din;
    end
    assign next_out = din;
  end else begin : g_chain
    always_ff @(posedge clk or posedge rst) begin
      if (rst) stages <= '0;
      else     stages <= {stages[DEPTH-2:0], din};
    end
    assign next_out = stages[DEPTH-2];
  end

  assign dout    = stages[DEPTH-1];
  assign any_set = |stages;

endmodule

// File: rtl/tpu_run_sequencer.sv
// Sequences one matrix-multiply run: weight tile pop, weight reload, UB row
// streaming and result-SRAM write strobes aligned to the array pipeline.
module tpu_run_sequencer
  import tpu_ctrl_pkg::*;
#(
  parameter int ADDRESSSIZE = ADDRESSSIZE_DEF,
  parameter int LOAD_CYCLES = LOAD_CYCLES_DEF,
  parameter int PIPE_LAT    = PIPE_LAT_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDRESSSIZE-1:0] cfg_base_addr,
  input  logic [ADDRESSSIZE-1:0] cfg_num_vec,
  input  logic [ADDRESSSIZE-1:0] cfg_res_base,
  input  logic                   fifo_empty,
  output logic                   fifo_rd_en,
  output logic                   we_rl,
  output logic [ADDRESSSIZE-1:0] ub_addr,
  output logic                   ub_addr_valid,
  output logic                   res_we,
  output logic [ADDRESSSIZE-1:0] res_addr,
  output logic                   busy,
  output logic                   done
);

  localparam int LCW = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;

  state_t                 state_q, state_d;
  logic [LCW-1:0]         load_cnt_q, load_cnt_d;
  logic [ADDRESSSIZE-1:0] rows_left_q, rows_left_d;
  logic [ADDRESSSIZE-1:0] row_ptr_q;
  logic [ADDRESSSIZE-1:0] res_ptr_q;
  logic                   dl_out, dl_next, dl_any;
  logic                   drain_done;

  valid_delay_line #(
    .DEPTH(PIPE_LAT)
  ) u_valid_delay (
    .clk     (clk),
    .rst     (rst),
    .din     (ub_addr_valid),
    .dout    (dl_out),
    .next_out(dl_next),
    .any_set (dl_any)
  );

  // Valid bits form one contiguous block, so the line empties on the next edge
  // once only the final stage still holds a 1.
  assign drain_done = !dl_any || (dl_out && !dl_next);
  assign res_we     = dl_out;

  always_comb begin
    state_d     = state_q;
    load_cnt_d  = load_cnt_q;
    rows_left_d = rows_left_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          rows_left_d = cfg_num_vec;
          state_d     = (cfg_num_vec == '0) ? S_DONE : S_WFIFO;
        end
      end
      S_WFIFO: begin
        if (!fifo_empty) state_d = S_POP;
      end
      S_POP: begin
        load_cnt_d = '0;
        state_d    = S_LOAD;
      end
      S_LOAD: begin
        if (load_cnt_q == LCW'(LOAD_CYCLES - 1)) state_d = S_STREAM;
        else load_cnt_d = load_cnt_q + LCW'(1);
      end
      S_STREAM: begin
        rows_left_d = rows_left_q - ADDRESSSIZE'(1);
        if (rows_left_q == ADDRESSSIZE'(1)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_done) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they change in lockstep with
  // the state register and never glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      load_cnt_q    <= '0;
      rows_left_q   <= '0;
      row_ptr_q     <= '0;
      res_ptr_q     <= '0;
      fifo_rd_en    <= 1'b0;
      we_rl         <= 1'b0;
      ub_addr       <= '0;
      ub_addr_valid <= 1'b0;
      res_addr      <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state_q       <= state_d;
      load_cnt_q    <= load_cnt_d;
      rows_left_q   <= rows_left_d;
      fifo_rd_en    <= (state_d == S_POP);
      we_rl         <= (state_d == S_LOAD);
      ub_addr_valid <= (state_d == S_STREAM);
      busy          <= (state_d != S_IDLE);
      done          <= (state_d == S_DONE);
      if (state_q == S_IDLE && start) begin
        row_ptr_q <= cfg_base_addr;
        res_ptr_q <= cfg_res_base;
      end
      if (state_d == S_STREAM) begin
        ub_addr   <= row_ptr_q;
        row_ptr_q <= row_ptr_q + ADDRESSSIZE'(1);
      end
      if (dl_next) begin
        res_addr  <= res_ptr_q;
        res_ptr_q <= res_ptr_q + ADDRESSSIZE'(1);
      end
    end
  end

endmodule

// File: tb/tb_tpu_run_sequencer.sv
// Scoreboard bench for tpu_run_sequencer: stimulus queues timed expected events,
// a negedge monitor pops and compares them as the DUT presents outputs.
module tb_tpu_run_sequencer;

  localparam int AW       = 10;
  localparam int LOAD     = 8;
  localparam int PIPE     = 18;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
  } ev_t;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW-1:0] cfg_base_addr;
  logic [AW-1:0] cfg_num_vec;
  logic [AW-1:0] cfg_res_base;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic          we_rl;
  logic [AW-1:0] ub_addr;
  logic          ub_addr_valid;
  logic          res_we;
  logic [AW-1:0] res_addr;
  logic          busy;
  logic          done;

  int  cyc = 0;
  int  checks = 0;
  int  passes = 0;
  logic prev_empty = 1'b1;

  int  exp_pop[$];
  int  exp_we[$];
  int  exp_done[$];
  ev_t exp_ub[$];
  ev_t exp_res[$];

  tpu_run_sequencer #(
    .ADDRESSSIZE(AW),
    .LOAD_CYCLES(LOAD),
    .PIPE_LAT   (PIPE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .cfg_base_addr(cfg_base_addr),
    .cfg_num_vec  (cfg_num_vec),
    .cfg_res_base (cfg_res_base),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .we_rl        (we_rl),
    .ub_addr      (ub_addr),
    .ub_addr_valid(ub_addr_valid),
    .res_we       (res_we),
    .res_addr     (res_addr),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_cycle(input int c);
    while (cyc < c) step();
  endtask

  // Expected timeline relative to the pop cycle p.
  task automatic schedule(input int p, input logic [AW-1:0] base,
                          input logic [AW-1:0] n, input logic [AW-1:0] rbase);
    ev_t e;
    exp_pop.push_back(p);
    for (int i = 0; i < LOAD; i++) exp_we.push_back(p + 1 + i);
    for (int i = 0; i < int'(n); i++) begin
      e.cyc  = p + 1 + LOAD + i;
      e.addr = AW'(int'(base) + i);
      exp_ub.push_back(e);
      e.cyc  = p + 1 + LOAD + PIPE + i;
      e.addr = AW'(int'(rbase) + i);
      exp_res.push_back(e);
    end
    exp_done.push_back(p + 1 + LOAD + PIPE + int'(n));
  endtask

  task automatic apply_stimulus(input logic [AW-1:0] base, input logic [AW-1:0] n,
                                input logic [AW-1:0] rbase, input int empty_cycles,
                                output int pop_cyc, output int done_cyc);
    int k;
    cfg_base_addr = base;
    cfg_num_vec   = n;
    cfg_res_base  = rbase;
    start         = 1'b1;
    k             = cyc;
    pop_cyc       = -1;
    if (n == '0) begin
      fifo_empty = 1'b0;
      exp_done.push_back(k + 1);
      done_cyc = k + 1;
      step();
      start = 1'b0;
    end else if (empty_cycles == 0) begin
      fifo_empty = 1'b0;
      pop_cyc    = k + 2;
      schedule(pop_cyc, base, n, rbase);
      done_cyc = pop_cyc + 1 + LOAD + PIPE + int'(n);
      step();
      start = 1'b0;
    end else begin
      fifo_empty = 1'b1;
      step();
      start = 1'b0;
      goto_cycle(k + empty_cycles);
      fifo_empty = 1'b0;
      pop_cyc    = cyc + 1;
      schedule(pop_cyc, base, n, rbase);
      done_cyc = pop_cyc + 1 + LOAD + PIPE + int'(n);
    end
  endtask

  task automatic check_idle_after(input int done_cyc, input string tag);
    goto_cycle(done_cyc + 1);
    check_output({tag, " busy back low"}, int'(busy), 0);
    check_output({tag, " pops left"}, exp_pop.size(), 0);
    check_output({tag, " we_rl left"}, exp_we.size(), 0);
    check_output({tag, " ub rows left"}, exp_ub.size(), 0);
    check_output({tag, " res writes left"}, exp_res.size(), 0);
    check_output({tag, " done left"}, exp_done.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, " control outs"},
                 int'({fifo_rd_en, we_rl, ub_addr_valid, res_we, busy, done}), 0);
    check_output({tag, " ub_addr"}, int'(ub_addr), 0);
    check_output({tag, " res_addr"}, int'(res_addr), 0);
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (fifo_rd_en) begin
      if (exp_pop.size() == 0) check_output("unexpected pop", 1, 0);
      else check_output("pop cycle", cyc, exp_pop.pop_front());
      check_output("pop while fifo empty", int'(prev_empty), 0);
    end
    if (we_rl) begin
      if (exp_we.size() == 0) check_output("unexpected we_rl", 1, 0);
      else check_output("we_rl cycle", cyc, exp_we.pop_front());
    end
    if (ub_addr_valid) begin
      if (exp_ub.size() == 0) check_output("unexpected ub row", 1, 0);
      else begin
        e = exp_ub.pop_front();
        check_output("ub row cycle", cyc, e.cyc);
        check_output("ub_addr", int'(ub_addr), int'(e.addr));
      end
    end
    if (res_we) begin
      if (exp_res.size() == 0) check_output("unexpected res_we", 1, 0);
      else begin
        e = exp_res.pop_front();
        check_output("res_we cycle", cyc, e.cyc);
        check_output("res_addr", int'(res_addr), int'(e.addr));
      end
    end
    if (done) begin
      if (exp_done.size() == 0) check_output("unexpected done", 1, 0);
      else check_output("done cycle", cyc, exp_done.pop_front());
      check_output("busy during done", int'(busy), 1);
    end
    prev_empty = fifo_empty;
  end

  initial begin
    int p, d;
    rst           = 1'b1;
    start         = 1'b0;
    cfg_base_addr = '0;
    cfg_num_vec   = '0;
    cfg_res_base  = '0;
    fifo_empty    = 1'b1;
    repeat (3) step();
    check_all_zero("reset state");
    rst = 1'b0;
    step();

    $display("[TB] basic run base=5 n=4 res_base=100");
    apply_stimulus(10'd5, 10'd4, 10'd100, 0, p, d);
    check_idle_after(d, "basic");

    $display("[TB] weight fifo empty for 10 cycles");
    apply_stimulus(10'd200, 10'd2, 10'd300, 10, p, d);
    check_idle_after(d, "fifo wait");

    $display("[TB] address wrap base=1022 res_base=1023");
    apply_stimulus(10'd1022, 10'd4, 10'd1023, 0, p, d);
    check_idle_after(d, "wrap");

    $display("[TB] empty run n=0");
    apply_stimulus(10'd7, 10'd0, 10'd9, 0, p, d);
    check_idle_after(d, "n0");

    $display("[TB] reset at third streamed row");
    apply_stimulus(10'd20, 10'd6, 10'd50, 0, p, d);
    goto_cycle(p + 1 + LOAD + 2);
    rst = 1'b1;
    exp_pop.delete();
    exp_we.delete();
    exp_ub.delete();
    exp_res.delete();
    exp_done.delete();
    #1;
    check_all_zero("async reset");
    step();
    rst = 1'b0;
    step();
    check_output("idle after reset", int'(busy), 0);
    apply_stimulus(10'd60, 10'd3, 10'd70, 0, p, d);
    check_idle_after(d, "post reset");

    $display("[TB] starts while busy and in the done cycle");
    apply_stimulus(10'd80, 10'd3, 10'd90, 0, p, d);
    goto_cycle(p + 3);
    cfg_base_addr = 10'd400;
    cfg_num_vec   = 10'd0;
    start         = 1'b1;
    step();
    start = 1'b0;
    goto_cycle(p + 1 + LOAD + 1);
    cfg_num_vec = 10'd5;
    start       = 1'b1;
    step();
    start = 1'b0;
    goto_cycle(d);
    check_output("busy in done cycle", int'(busy), 1);
    cfg_base_addr = 10'd500;
    cfg_num_vec   = 10'd2;
    start         = 1'b1;
    step();
    apply_stimulus(10'd600, 10'd2, 10'd700, 0, p, d);
    check_idle_after(d, "back to back");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
